// File: rtl/sb_bus_initiator.sv
// sb_bus_initiator: single-outstanding register-access master for the
// SB_I2C / SB_SPI hard-IP system bus. It turns a user valid/ready command
// into a strobed bus cycle, waits for the acknowledge (bounded by TIMEOUT),
// returns a one-cycle response, and always leaves one idle cycle with the
// strobe low before the next command can start.
module sb_bus_initiator #(
    parameter logic [3:0]  BUS_ADDR74 = 4'b0001, // upper nibble of the hard-IP register block
    parameter int unsigned TIMEOUT    = 16       // max strobe-high cycles without ack (2..255)
) (
    input  logic       sbclki,
    input  logic       sbrsti,
    // user command side
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    // user response side
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    // hard-IP system bus
    output logic       sbstbi,
    output logic       sbrwi,
    output logic [7:0] sbadri,
    output logic [7:0] sbdati,
    input  logic [7:0] sbdato,
    input  logic       sbacko
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Counter value seen on the last permitted ACCESS edge. TIMEOUT is at
    // most 255, so the 8-bit counter never wraps before this compare hits.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       rdy_q;
    logic       stb_q;
    logic       rw_q;
    logic [7:0] adr_q;
    logic [7:0] dat_q;
    logic       rvld_q;
    logic [7:0] rdata_q;
    logic       rto_q;

    // Whole initiator FSM with every output held in a register.
    always_ff @(posedge sbclki or posedge sbrsti) begin
        if (sbrsti) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            rdy_q   <= 1'b1;
            stb_q   <= 1'b0;
            rw_q    <= 1'b0;
            adr_q   <= 8'h00;
            dat_q   <= 8'h00;
            rvld_q  <= 1'b0;
            rdata_q <= 8'h00;
            rto_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The bus is quiet here; any stray sbacko is ignored.
                    if (cmd_valid && rdy_q) begin
                        state_q <= ACCESS;
                        rdy_q   <= 1'b0;
                        stb_q   <= 1'b1;
                        rw_q    <= cmd_rw;
                        adr_q   <= {BUS_ADDR74, cmd_addr};
                        dat_q   <= cmd_rw ? cmd_wdata : 8'h00;
                        cnt_q   <= 8'h00;
                    end
                end

                ACCESS: begin
                    // Acknowledge takes priority over a timeout on the same edge.
                    if (sbacko || (cnt_q == CNT_LAST)) begin
                        state_q <= RELEASE;
                        stb_q   <= 1'b0;
                        rw_q    <= 1'b0;
                        adr_q   <= 8'h00;
                        dat_q   <= 8'h00;
                        rvld_q  <= 1'b1;
                        rto_q   <= ~sbacko;
                        rdata_q <= (sbacko && !rw_q) ? sbdato : 8'h00;
                    end else begin
                        cnt_q <= cnt_q + 8'h01;
                    end
                end

                RELEASE: begin
                    // One forced strobe-low cycle before the next command.
                    state_q <= IDLE;
                    rvld_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    stb_q   <= 1'b0;
                    rvld_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = rdy_q;
    assign rsp_valid   = rvld_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = rto_q;
    assign sbstbi      = stb_q;
    assign sbrwi       = rw_q;
    assign sbadri      = adr_q;
    assign sbdati      = dat_q;

endmodule
